// File: rtl/mmm_rreg_shift.sv
// mmm_rreg_shift: Montgomery R_i holding register with load, LSB-first shift-out, busy/done handshake.
// Optional feature: define MMM_RREG_CONDSUB_EN to reduce unlocked loads by mod_m (A >= mod_m -> A - mod_m).
module mmm_rreg_shift #(
  parameter int WIDTH = 10,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             rst_mmm_i,
  input  logic             en,
  input  logic             lock,
  input  logic             ld_r,
  input  logic [WIDTH-1:0] reg_rji,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] mod_m,
  input  logic             shift_start,
  input  logic             ser_i,
  output logic [WIDTH-1:0] R_i,
  output logic             ser_o,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] r_n, a_ld;
  logic             arst_n;
  // Both clears are active-low; either one wipes the register asynchronously.
  assign arst_n = rstb & rst_mmm_i;
  assign ser_o  = R_i[0];
`ifdef MMM_RREG_CONDSUB_EN
  // Single conditional subtraction keeps an unlocked load inside [0, mod_m) for inputs below 2*mod_m.
  assign a_ld = (A >= mod_m) ? A - mod_m : A;
`else
  logic unused_mod;
  assign unused_mod = ^mod_m;
  assign a_ld = A;
`endif
  // Next-state logic: a load beats everything and aborts any shift in progress.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    r_n     = R_i;
    if (ld_r) begin
      r_n     = lock ? reg_rji : a_ld;
      cnt_n   = '0;
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          cnt_n   = shift_start ? CNT_W'(WIDTH) : cnt;
          state_n = shift_start ? SHIFT : IDLE;
        end
        SHIFT: begin
          r_n     = {ser_i, R_i[WIDTH-1:1]};
          cnt_n   = cnt - CNT_W'(1);
          state_n = (cnt == CNT_W'(1)) ? DONE : SHIFT;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  // State register; busy tracks SHIFT, done is a one-enabled-cycle pulse that clears whenever not regenerated.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
      cnt   <= '0;
      R_i   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (en) begin
      state <= state_n;
      cnt   <= cnt_n;
      R_i   <= r_n;
      busy  <= state_n == SHIFT;
      done  <= state_n == DONE;
    end else begin
      done  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mmm_rreg_shift.sv
// tb_mmm_rreg_shift: scoreboard bench; stimulus queues expected serial bits and completion results, a monitor checks them.
module tb_mmm_rreg_shift;
  typedef struct {logic [9:0] r; int len;} fin_t;
  logic clk = 0, rstb = 0, rst_mmm_i = 1, en = 1, lock = 0, ld_r = 0, shift_start = 0, ser_i = 0;
  logic [9:0] reg_rji = 0, A = 0, mod_m = 10'h3FF;
  logic [9:0] R_i;
  logic ser_o, busy, done;
  int n_cmp = 0, n_bad = 0, blen = 0;
  logic exp_ser[$];
  fin_t exp_fin[$];
  mmm_rreg_shift #(.WIDTH(10)) dut (
    .clk(clk), .rstb(rstb), .rst_mmm_i(rst_mmm_i), .en(en), .lock(lock), .ld_r(ld_r),
    .reg_rji(reg_rji), .A(A), .mod_m(mod_m), .shift_start(shift_start), .ser_i(ser_i),
    .R_i(R_i), .ser_o(ser_o), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic load(input logic lk, input logic [9:0] rj, input logic [9:0] a);
    lock = lk; reg_rji = rj; A = a; ld_r = 1;
    step(1);
    ld_r = 0;
  endtask
  task automatic start();
    shift_start = 1;
    step(1);
    shift_start = 0;
  endtask
  task automatic expect_shift(input logic [9:0] w, input int nbits);
    for (int k = 0; k < nbits; k++) exp_ser.push_back(w[k]);
  endtask
  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && exp_fin.size() != 0; i++) step(1);
    chk("done_seen_pending", exp_fin.size(), 0);
  endtask
  always @(negedge clk) begin
    if (busy) begin
      blen++;
      if (en && !ld_r) begin
        if (exp_ser.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL ser_extra: shift with no expected bit, ser_o=%0b", ser_o);
        end else chk("ser_o", int'(ser_o), int'(exp_ser.pop_front()));
      end
    end else if (done) begin
      if (exp_fin.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL done_unexpected: done=1 with nothing pending, R_i=0x%0h", R_i);
      end else begin
        fin_t f;
        f = exp_fin.pop_front();
        chk("final_R_i", int'(R_i), int'(f.r));
        chk("busy_len", blen, f.len);
      end
      blen = 0;
    end else blen = 0;
  end
  initial begin
    step(2);
    chk("rst_R_i", int'(R_i), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rstb = 1;
    step(1);
    load(1, 10'h2AA, 10'h155);
    chk("load_locked", int'(R_i), 'h2AA);
    load(0, 10'h2AA, 10'h155);
    chk("load_unlocked", int'(R_i), 'h155);
    step(5);
    chk("hold", int'(R_i), 'h155);
    load(0, 0, 10'h2D3);
    expect_shift(10'h2D3, 10);
    exp_fin.push_back('{10'h000, 10});
    start();
    chk("busy_after_start", int'(busy), 1);
    wait_done(20);
    step(1);
    chk("done_one_cycle", int'(done), 0);
    chk("busy_idle", int'(busy), 0);
    load(0, 0, 10'h2D3);
    expect_shift(10'h2D3, 10);
    exp_fin.push_back('{10'h000, 13});
    start();
    step(3);
    en = 0;
    step(3);
    chk("freeze_R_i", int'(R_i), 'h05A);
    chk("freeze_busy", int'(busy), 1);
    en = 1;
    wait_done(20);
    load(0, 0, 10'h2D3);
    expect_shift(10'h2D3, 3);
    start();
    step(3);
    load(0, 0, 10'h0F0);
    chk("abort_R_i", int'(R_i), 'h0F0);
    chk("abort_busy", int'(busy), 0);
    step(12);
    chk("abort_no_done", int'(done), 0);
    shift_start = 1;
    load(0, 0, 10'h111);
    shift_start = 0;
    chk("collide_R_i", int'(R_i), 'h111);
    chk("collide_busy", int'(busy), 0);
    step(2);
    chk("collide_busy_later", int'(busy), 0);
    expect_shift(10'h111, 10);
    exp_fin.push_back('{10'h000, 10});
    start();
    step(4);
    start();
    wait_done(20);
    load(0, 0, 10'h155);
    ser_i = 1;
    expect_shift(10'h155, 10);
    exp_fin.push_back('{10'h3FF, 10});
    start();
    wait_done(20);
    ser_i = 0;
    step(1);
    load(0, 0, 10'h2D3);
    expect_shift(10'h2D3, 10);
    start();
    step(4);
    #2 rstb = 0;
    #1;
    chk("arst_R_i", int'(R_i), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    step(1);
    exp_ser.delete();
    rstb = 1;
    step(1);
    load(1, 10'h3C3, 0);
    chk("reload", int'(R_i), 'h3C3);
    #2 rst_mmm_i = 0;
    #1;
    chk("mmm_clr_R_i", int'(R_i), 0);
    chk("mmm_clr_busy", int'(busy), 0);
    step(1);
    rst_mmm_i = 1;
    step(12);
    chk("clr_no_done", int'(done), 0);
    mod_m = 10'h301;
    load(0, 0, 10'h3FF);
`ifdef MMM_RREG_CONDSUB_EN
    chk("condsub_reduce", int'(R_i), 'h0FE);
`else
    chk("condsub_off", int'(R_i), 'h3FF);
`endif
    load(0, 0, 10'h300);
    chk("condsub_below", int'(R_i), 'h300);
    load(1, 10'h3FF, 10'h3FF);
    chk("condsub_locked", int'(R_i), 'h3FF);
    step(2);
    chk("ser_left", exp_ser.size(), 0);
    chk("fin_left", exp_fin.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
